uart_rx_param: RTL and testbench

Parametrised UART receiver that replaces the fixed 8N1 receiver inside the FPGA top-level UART path. It deserialises the asynchronous `rxd` line into words of configurable width, with optional parity and one or two stop bits. Each received word is pushed into an internal FIFO with per-word parity and framing error flags. A valid/ready read port feeds the image-loading logic, which uploads the 5183-byte input frames, so that a slow consumer no longer loses bytes.

---
 rtl/uart_rx_param_if.sv | 27 ++
 rtl/uart_rx_param.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Read-side handshake between the UART receiver FIFO and its consumer.
// The receiver drives the head word; the consumer drives rx_ready.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_valid;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_perr;
    logic                 rx_ferr;

    modport master (
        output rx_valid,
        output rx_data,
        output rx_perr,
        output rx_ferr,
        input  rx_ready
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  rx_perr,
        input  rx_ferr,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-vote bit sampling, optional parity,
// 1 or 2 stop bits, and a receive FIFO with per-word error flags.
module uart_rx_param #(
    parameter int CLK_FREQ   = 200_000_000,
    parameter int UART_BPS   = 2_000_000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk200M,
    input  logic                        rstn,
    input  logic                        rxd,
    input  logic                        ovf_clr,
    uart_rx_param_if.master             rd,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    output logic                        rx_ovf,
    output logic                        rx_busy
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int MID     = BPS_CNT / 2;
    localparam int CNT_W   = $clog2(BPS_CNT);
    localparam int BIT_W   = $clog2(DATA_BITS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int WORD_W  = DATA_BITS + 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t state, next_state;

    logic                 rxd_meta, rxs, rxs_prev;
    logic [CNT_W-1:0]     bcnt;
    logic                 s0, s1;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr;
    logic                 push_pending;
    logic [WORD_W-1:0]    push_word;

    logic                 at_s0, at_s1, at_vote, vote;
    logic                 last_data, last_stop, push_now, par_err;

    logic [WORD_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [OCC_W-1:0]     count;
    logic                 full, pop, push_ok, ovf_set;
    logic [WORD_W-1:0]    head;

    assign at_s0     = (bcnt == CNT_W'(MID - 1));
    assign at_s1     = (bcnt == CNT_W'(MID));
    assign at_vote   = (bcnt == CNT_W'(MID + 1));
    assign vote      = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign last_data = (bit_idx == BIT_W'(DATA_BITS - 1));
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
    assign push_now  = (state == ST_STOP) && at_vote && last_stop;
    // Odd mode flags an error when data plus parity bit has even weight.
    assign par_err   = (PARITY == 1) ? ~(^shreg ^ vote) : (^shreg ^ vote);

    always_ff @(posedge clk200M or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (rxs_prev && !rxs) begin
                    next_state = ST_START;
                end
            end
            ST_START: begin
                if (at_vote) begin
                    next_state = vote ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_vote && last_data) begin
                    next_state = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (at_vote) begin
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_vote && last_stop) begin
                    next_state = vote ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk200M or negedge rstn) begin
        if (!rstn) begin
            rxd_meta     <= 1'b1;
            rxs          <= 1'b1;
            rxs_prev     <= 1'b1;
            bcnt         <= '0;
            s0           <= 1'b1;
            s1           <= 1'b1;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            push_pending <= 1'b0;
            push_word    <= '0;
        end else begin
            rxd_meta     <= rxd;
            rxs          <= rxd_meta;
            rxs_prev     <= rxs;
            push_pending <= push_now;

            // The bit clock restarts on every start edge, so sampling is
            // aligned to the frame that is actually arriving.
            if (state == ST_IDLE) begin
                bcnt     <= '0;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                perr     <= 1'b0;
                ferr     <= 1'b0;
            end else if (bcnt == CNT_W'(BPS_CNT - 1)) begin
                bcnt <= '0;
            end else begin
                bcnt <= bcnt + CNT_W'(1);
            end

            if (at_s0) begin
                s0 <= rxs;
            end
            if (at_s1) begin
                s1 <= rxs;
            end

            if (at_vote) begin
                case (state)
                    ST_DATA: begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BIT_W'(1);
                    end
                    ST_PARITY: begin
                        perr <= par_err;
                    end
                    ST_STOP: begin
                        stop_idx <= 1'b1;
                        if (!vote) begin
                            ferr <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (push_now) begin
                push_word <= {perr, ferr | ~vote, shreg};
            end
        end
    end

    assign full    = (count == OCC_W'(FIFO_DEPTH));
    assign pop     = rd.rx_valid && rd.rx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    assign push_ok = push_pending && (!full || pop);
    assign ovf_set = push_pending && full && !pop;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk200M) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk200M or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rx_ovf <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
            rx_ovf <= ovf_set | (rx_ovf & ~ovf_clr);
        end
    end

    assign rd.rx_valid = (count != '0);
    assign rd.rx_data  = rd.rx_valid ? head[DATA_BITS-1:0] : '0;
    assign rd.rx_ferr  = rd.rx_valid ? head[DATA_BITS]     : 1'b0;
    assign rd.rx_perr  = rd.rx_valid ? head[DATA_BITS+1]   : 1'b0;
    assign rx_count    = count;
    assign rx_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 receiver and an 8E1 receiver
// fed hand-built frames at 100 clocks per bit.
module tb_uart_rx_param;

    localparam int BPS = 100;

    logic       clk200M = 1'b0;
    logic       rstn    = 1'b0;
    logic       rxd_a   = 1'b1;
    logic       rxd_b   = 1'b1;
    logic       ovf_clr_a = 1'b0;
    logic       ovf_clr_b = 1'b0;
    logic [4:0] count_a, count_b;
    logic       ovf_a, ovf_b, busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cycles_a = 0;

    logic [9:0] q_a[$];
    logic [9:0] q_b[$];

    uart_rx_param_if #(.DATA_BITS(8)) if_a ();
    uart_rx_param_if #(.DATA_BITS(8)) if_b ();

    uart_rx_param #(
        .CLK_FREQ(200_000_000), .UART_BPS(2_000_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut_a (
        .clk200M(clk200M), .rstn(rstn), .rxd(rxd_a), .ovf_clr(ovf_clr_a),
        .rd(if_a), .rx_count(count_a), .rx_ovf(ovf_a), .rx_busy(busy_a)
    );

    uart_rx_param #(
        .CLK_FREQ(200_000_000), .UART_BPS(2_000_000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut_b (
        .clk200M(clk200M), .rstn(rstn), .rxd(rxd_b), .ovf_clr(ovf_clr_b),
        .rd(if_b), .rx_count(count_b), .rx_ovf(ovf_b), .rx_busy(busy_b)
    );

    always #5 clk200M = ~clk200M;

    // Every word the consumer accepts is logged as {perr, ferr, data}.
    always @(negedge clk200M) begin
        if (if_a.rx_valid && if_a.rx_ready) q_a.push_back({if_a.rx_perr, if_a.rx_ferr, if_a.rx_data});
        if (if_b.rx_valid && if_b.rx_ready) q_b.push_back({if_b.rx_perr, if_b.rx_ferr, if_b.rx_data});
        if (if_a.rx_valid) valid_cycles_a++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk200M);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives nbits frame bits (LSB first, start bit included) and leaves the line idle.
    task automatic applyStimulus(input bit to_b, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (to_b) rxd_b = bits[i];
            else      rxd_a = bits[i];
            tick(BPS);
        end
        if (to_b) rxd_b = 1'b1;
        else      rxd_a = 1'b1;
    endtask

    initial begin
        int         base;
        int         vbase;
        int         waited;
        logic [9:0] got;
        logic [7:0] v8;

        if_a.rx_ready = 1'b0;
        if_b.rx_ready = 1'b0;
        tick(3);
        checkOutput("reset_valid", 32'(if_a.rx_valid), 32'h0);
        checkOutput("reset_data",  32'(if_a.rx_data),  32'h0);
        checkOutput("reset_count", 32'(count_a),       32'h0);
        checkOutput("reset_ovf",   32'(ovf_a),         32'h0);
        checkOutput("reset_busy",  32'(busy_a),        32'h0);
        checkOutput("reset_flags", 32'({if_a.rx_perr, if_a.rx_ferr}), 32'h0);
        rstn = 1'b1;
        tick(5);

        $display("[TB] 8N1 single word");
        if_a.rx_ready = 1'b1;
        if_b.rx_ready = 1'b1;
        base  = q_a.size();
        vbase = valid_cycles_a;
        applyStimulus(1'b0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
        tick(20);
        checkOutput("a5_words", 32'(q_a.size() - base), 32'd1);
        got = (q_a.size() > base) ? q_a[base] : 10'h3FF;
        checkOutput("a5_word", 32'(got), 32'h0A5);
        checkOutput("a5_valid_cycles", 32'(valid_cycles_a - vbase), 32'd1);

        $display("[TB] even parity");
        base = q_b.size();
        applyStimulus(1'b1, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        tick(20);
        applyStimulus(1'b1, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        tick(20);
        checkOutput("par_words", 32'(q_b.size() - base), 32'd2);
        got = (q_b.size() > base) ? q_b[base] : 10'h3FF;
        checkOutput("par_bad", 32'(got), 32'h207);
        got = (q_b.size() > base + 1) ? q_b[base + 1] : 10'h3FF;
        checkOutput("par_good", 32'(got), 32'h007);

        $display("[TB] glitch rejection");
        base  = q_a.size();
        rxd_a = 1'b0;
        tick(20);
        checkOutput("glitch_busy", 32'(busy_a), 32'h1);
        rxd_a  = 1'b1;
        waited = 0;
        while (busy_a && waited < BPS) begin
            tick(1);
            waited++;
        end
        checkOutput("glitch_idle", 32'(busy_a), 32'h0);
        tick(20);
        checkOutput("glitch_nopush", 32'(q_a.size() - base), 32'd0);

        $display("[TB] framing error");
        base = q_a.size();
        applyStimulus(1'b0, {6'd0, 1'b0, 8'h3C, 1'b0}, 10);
        tick(20);
        checkOutput("ferr_words", 32'(q_a.size() - base), 32'd1);
        got = (q_a.size() > base) ? q_a[base] : 10'h3FF;
        checkOutput("ferr_word", 32'(got), 32'h13C);

        $display("[TB] break");
        base  = q_a.size();
        rxd_a = 1'b0;
        tick(25 * BPS);
        checkOutput("break_words", 32'(q_a.size() - base), 32'd1);
        got = (q_a.size() > base) ? q_a[base] : 10'h3FF;
        checkOutput("break_word", 32'(got), 32'h100);
        rxd_a = 1'b1;
        tick(300);
        checkOutput("break_quiet", 32'(q_a.size() - base), 32'd1);
        applyStimulus(1'b0, {6'd0, 1'b1, 8'h81, 1'b0}, 10);
        tick(20);
        checkOutput("after_break_words", 32'(q_a.size() - base), 32'd2);
        got = (q_a.size() > base + 1) ? q_a[base + 1] : 10'h3FF;
        checkOutput("after_break_word", 32'(got), 32'h081);

        $display("[TB] overflow");
        if_a.rx_ready = 1'b0;
        base = q_a.size();
        for (int v = 0; v < 17; v++) begin
            v8 = 8'(v);
            applyStimulus(1'b0, {6'd0, 1'b1, v8, 1'b0}, 10);
        end
        tick(20);
        checkOutput("ovf_count", 32'(count_a), 32'd16);
        checkOutput("ovf_flag",  32'(ovf_a),   32'h1);
        if_a.rx_ready = 1'b1;
        tick(40);
        checkOutput("drain_words", 32'(q_a.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            got = (q_a.size() > base + i) ? q_a[base + i] : 10'h3FF;
            checkOutput($sformatf("drain_%0d", i), 32'(got), 32'(i));
        end
        checkOutput("drain_count", 32'(count_a), 32'd0);
        checkOutput("ovf_sticky",  32'(ovf_a),   32'h1);
        ovf_clr_a = 1'b1;
        tick(1);
        ovf_clr_a = 1'b0;
        tick(1);
        checkOutput("ovf_cleared", 32'(ovf_a), 32'h0);

        $display("[TB] reset mid-frame");
        if_a.rx_ready = 1'b0;
        applyStimulus(1'b0, {6'd0, 1'b1, 8'h11, 1'b0}, 10);
        applyStimulus(1'b0, {6'd0, 1'b1, 8'h22, 1'b0}, 10);
        applyStimulus(1'b0, {6'd0, 1'b1, 8'h33, 1'b0}, 10);
        tick(20);
        checkOutput("queued_count", 32'(count_a), 32'd3);
        rxd_a = 1'b0;
        tick(BPS);
        for (int i = 0; i < 4; i++) begin
            v8 = 8'h44;
            rxd_a = v8[i];
            tick(BPS);
        end
        checkOutput("midframe_busy", 32'(busy_a), 32'h1);
        rstn  = 1'b0;
        rxd_a = 1'b1;
        tick(2);
        checkOutput("rst_valid", 32'(if_a.rx_valid), 32'h0);
        checkOutput("rst_count", 32'(count_a),       32'h0);
        checkOutput("rst_busy",  32'(busy_a),        32'h0);
        checkOutput("rst_data",  32'(if_a.rx_data),  32'h0);
        rstn = 1'b1;
        tick(10);
        if_a.rx_ready = 1'b1;
        base = q_a.size();
        applyStimulus(1'b0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10);
        tick(20);
        checkOutput("post_rst_words", 32'(q_a.size() - base), 32'd1);
        got = (q_a.size() > base) ? q_a[base] : 10'h3FF;
        checkOutput("post_rst_word", 32'(got), 32'h05A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
